// File: rtl/sram_arbiter.sv
// Arbitrates one single-port data SRAM between the CPU MEM stage and a DMA port.
// CPU has fixed priority; a waiting DMA is forced through after MAX_WAIT lost cycles.
module sram_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 1,
  parameter int MAX_WAIT      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic              sram_re,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wdata_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DMA} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] dma_wait;

  logic cpu_elig, dma_elig, dma_force, grant_cpu, grant_dma;

  // A requester whose ack is high this cycle is still holding its old req,
  // so it must not be granted again until req survives past the ack cycle.
  assign cpu_elig  = cpu_req & ~cpu_ack;
  assign dma_elig  = dma_req & ~dma_ack;
  assign dma_force = dma_elig && (dma_wait == WAIT_W'(MAX_WAIT));
  assign grant_dma = (state == IDLE) && (dma_force || (dma_elig && !cpu_elig));
  assign grant_cpu = (state == IDLE) && cpu_elig && !dma_force;

  assign cpu_stall     = cpu_req & ~cpu_ack;
  assign sram_wdata_oe = sram_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dma_wait   <= '0;
      sram_addr  <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      sram_wdata <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;

      if (!dma_req || grant_dma) begin
        dma_wait <= '0;
      end else if (dma_wait != WAIT_W'(MAX_WAIT)) begin
        dma_wait <= dma_wait + WAIT_W'(1);
      end

      case (state)
        IDLE: begin
          if (grant_dma) begin
            sram_addr  <= dma_addr;
            sram_wdata <= dma_wdata;
            sram_we    <= dma_we;
            sram_re    <= ~dma_we;
            cnt        <= CNT_W'(ACCESS_CYCLES - 1);
            state      <= BUSY_DMA;
          end else if (grant_cpu) begin
            sram_addr  <= cpu_addr;
            sram_wdata <= cpu_wdata;
            sram_we    <= cpu_we;
            sram_re    <= ~cpu_we;
            cnt        <= CNT_W'(ACCESS_CYCLES - 1);
            state      <= BUSY_CPU;
          end
        end
        BUSY_CPU, BUSY_DMA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (state == BUSY_CPU) begin
              if (sram_re) cpu_rdata <= sram_rdata;
              cpu_ack <= 1'b1;
            end else begin
              if (sram_re) dma_rdata <= sram_rdata;
              dma_ack <= 1'b1;
            end
            sram_we <= 1'b0;
            sram_re <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
